branch_predictor: RTL

Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry. The IF stage looks up the current PC combinationally and gets a taken/not-taken prediction and a next-PC target. The EX stage writes back the resolved outcome each cycle: the comparator's taken result plus the computed target. Together these close the loop between branch resolution and instruction fetch.

---
 rtl/branch_predictor_if.sv | 22 ++
 rtl/branch_predictor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Signal bundle between the fetch/execute stages and branch_predictor:
// IF-stage lookup (IF_PC -> Pred*) and EX-stage resolution write-back (Upd*).
interface branch_predictor_if;
  logic [31:0] IF_PC;
  logic        PredHit;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        UpdValid;
  logic [31:0] UpdPC;
  logic        UpdTaken;
  logic [31:0] UpdTarget;

  modport master (
    output IF_PC, UpdValid, UpdPC, UpdTaken, UpdTarget,
    input  PredHit, PredTaken, PredTarget
  );

  modport slave (
    input  IF_PC, UpdValid, UpdPC, UpdTaken, UpdTarget,
    output PredHit, PredTaken, PredTarget
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry; combinational lookup, one-cycle update.
// Optional BP_BYPASS_EN forwards a same-index update into the same-cycle lookup.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input logic          clk,
  input logic          rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case ({taken, ctr})
      3'b1_11: res = 2'b11;
      3'b0_00: res = 2'b00;
      default: res = taken ? (ctr + 2'd1) : (ctr - 2'd1);
    endcase
    return res;
  endfunction

  logic [ENTRIES-1:0] valid_r;
  logic [TAGW-1:0]    tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];

  logic [IDXW-1:0] updIdx_s;
  logic [TAGW-1:0] updTag_s;
  logic            updHit_s;
  logic            updWrite_s;
  logic            newValid_s;
  logic [TAGW-1:0] newTag_s;
  logic [31:0]     newTarget_s;
  logic [1:0]      newCtr_s;
  logic            unusedUpdLow_s;

  assign updIdx_s       = bp.UpdPC[IDXW+1:2];
  assign updTag_s       = bp.UpdPC[31:IDXW+2];
  assign updHit_s       = valid_r[updIdx_s] && (tag_r[updIdx_s] == updTag_s);
  assign unusedUpdLow_s = ^bp.UpdPC[1:0];

  // Next contents of the entry addressed by the resolving branch
  always_comb begin
    newValid_s  = valid_r[updIdx_s];
    newTag_s    = tag_r[updIdx_s];
    newTarget_s = target_r[updIdx_s];
    newCtr_s    = ctr_r[updIdx_s];
    updWrite_s  = 1'b0;
    if (bp.UpdValid) begin
      if (updHit_s) begin
        updWrite_s = 1'b1;
        newCtr_s   = ctrStep(ctr_r[updIdx_s], bp.UpdTaken);
        if (bp.UpdTaken) begin
          newTarget_s = bp.UpdTarget;
        end else begin
          newTarget_s = target_r[updIdx_s];
        end
      end else if (bp.UpdTaken) begin
        // Only taken branches earn an entry; they start weakly taken
        updWrite_s  = 1'b1;
        newValid_s  = 1'b1;
        newTag_s    = updTag_s;
        newTarget_s = bp.UpdTarget;
        newCtr_s    = 2'b10;
      end else begin
        updWrite_s = 1'b0;
      end
    end else begin
      updWrite_s = 1'b0;
    end
  end

  // Table storage: cleared on reset, one entry rewritten per accepted update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= {TAGW{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (updWrite_s) begin
      valid_r[updIdx_s]  <= newValid_s;
      tag_r[updIdx_s]    <= newTag_s;
      target_r[updIdx_s] <= newTarget_s;
      ctr_r[updIdx_s]    <= newCtr_s;
    end else begin
      valid_r <= valid_r;
    end
  end

  logic [IDXW-1:0] lkIdx_s;
  logic [TAGW-1:0] lkTagIn_s;
  logic            lkValid_s;
  logic [TAGW-1:0] lkTag_s;
  logic [31:0]     lkTarget_s;
  logic [1:0]      lkCtr_s;
  logic            predHit_s;
  logic            predTaken_s;

  assign lkIdx_s   = bp.IF_PC[IDXW+1:2];
  assign lkTagIn_s = bp.IF_PC[31:IDXW+2];

  // Entry state as seen by the fetch lookup
  always_comb begin
    lkValid_s  = valid_r[lkIdx_s];
    lkTag_s    = tag_r[lkIdx_s];
    lkTarget_s = target_r[lkIdx_s];
    lkCtr_s    = ctr_r[lkIdx_s];
`ifdef BP_BYPASS_EN
    if (rst_n && bp.UpdValid && (updIdx_s == lkIdx_s)) begin
      lkValid_s  = newValid_s;
      lkTag_s    = newTag_s;
      lkTarget_s = newTarget_s;
      lkCtr_s    = newCtr_s;
    end else begin
      lkValid_s  = valid_r[lkIdx_s];
    end
`endif
  end

  assign predHit_s     = lkValid_s && (lkTag_s == lkTagIn_s);
  assign predTaken_s   = predHit_s && lkCtr_s[1];
  assign bp.PredHit    = predHit_s;
  assign bp.PredTaken  = predTaken_s;
  assign bp.PredTarget = predTaken_s ? lkTarget_s : (bp.IF_PC + 32'd4);
endmodule
